// File: rtl/hqm_aw_tx_sync.sv
`timescale 1ns/1ps
// Transmit-side synchronizing FIFO: external 1R1W memory FIFO feeding a 2-entry
// registered output buffer, with bypass straight into the buffer when the memory path is empty.
module hqm_aw_tx_sync #(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 16,
  parameter int DEPTHB2 = $clog2(DEPTH),
  parameter int CWIDTH  = $clog2(DEPTH + 3)
) (
  input  logic               hqm_inp_gated_clk,
  input  logic               hqm_inp_gated_rst,
  input  logic               enable,
  output logic               idle,
  input  logic               rst_prep,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               mem_we,
  output logic [DEPTHB2-1:0] mem_waddr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic               mem_re,
  output logic [DEPTHB2-1:0] mem_raddr,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic [CWIDTH-1:0]  status_depth,
  output logic               status_full,
  output logic               status_empty
);

  localparam logic [CWIDTH-1:0]  DEPTH_C  = CWIDTH'(DEPTH);
  localparam logic [DEPTHB2-1:0] LAST_PTR = DEPTHB2'(DEPTH - 1);

  logic                clk;
  logic                rst;
  logic [DEPTHB2-1:0]  wptr_reg, wptr_next;
  logic [DEPTHB2-1:0]  rptr_reg, rptr_next;
  logic [CWIDTH-1:0]   mem_cnt_reg, mem_cnt_next;
  logic                rd_inflight_reg, rd_inflight_next;
  logic [1:0]          ob_cnt_reg, ob_cnt_next;
  logic [WIDTH-1:0]    ob_data_reg [2];
  logic [WIDTH-1:0]    ob_data_next [2];

  logic                push;
  logic                pop;
  logic                bypass;
  logic                ob_load;
  logic [WIDTH-1:0]    load_data;
  logic [1:0]          ob_after_pop;
  logic [2:0]          ob_pending;
  logic [CWIDTH-1:0]   depth_sum;

  assign clk = hqm_inp_gated_clk;
  assign rst = hqm_inp_gated_rst;

  always_comb begin
    in_ready         = ~rst & enable & ~rst_prep & (mem_cnt_reg < DEPTH_C);
    push             = in_valid & in_ready;
    out_valid        = ~rst & ~rst_prep & (ob_cnt_reg != 2'd0);
    pop              = out_valid & out_ready;
    ob_after_pop     = ob_cnt_reg - {1'b0, pop};
    // Bypass only while nothing older sits in memory or in flight, so order is preserved.
    bypass           = push & (mem_cnt_reg == '0) & ~rd_inflight_reg & (ob_after_pop < 2'd2);
    mem_we           = push & ~bypass;
    ob_pending       = {1'b0, ob_after_pop} + {2'b00, rd_inflight_reg};
    mem_re           = ~rst & ~rst_prep & (mem_cnt_reg != '0) & (ob_pending < 3'd2);
    // An in-flight read and a bypass are mutually exclusive, so at most one load per cycle.
    ob_load          = rd_inflight_reg | bypass;
    load_data        = rd_inflight_reg ? mem_rdata : in_data;
    ob_cnt_next      = ob_after_pop + {1'b0, ob_load};
    rd_inflight_next = mem_re;
    mem_cnt_next     = mem_cnt_reg + CWIDTH'(mem_we) - CWIDTH'(mem_re);
    wptr_next        = wptr_reg;
    rptr_next        = rptr_reg;
    if (mem_we) begin
      wptr_next = (wptr_reg == LAST_PTR) ? '0 : wptr_reg + 1'b1;
    end
    if (mem_re) begin
      rptr_next = (rptr_reg == LAST_PTR) ? '0 : rptr_reg + 1'b1;
    end
  end

  // Each buffer slot either shifts toward the head on pop or takes the incoming word.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ob
    logic [WIDTH-1:0] shifted;
    if (gi == 0) begin : g_head
      assign shifted = pop ? ob_data_reg[1] : ob_data_reg[0];
    end else begin : g_tail
      assign shifted = ob_data_reg[1];
    end
    assign ob_data_next[gi] = (ob_load && (ob_after_pop == 2'(gi))) ? load_data : shifted;

    always_ff @(posedge clk) begin
      ob_data_reg[gi] <= ob_data_next[gi];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg        <= '0;
      rptr_reg        <= '0;
      mem_cnt_reg     <= '0;
      rd_inflight_reg <= 1'b0;
      ob_cnt_reg      <= 2'd0;
    end else begin
      wptr_reg        <= wptr_next;
      rptr_reg        <= rptr_next;
      mem_cnt_reg     <= mem_cnt_next;
      rd_inflight_reg <= rd_inflight_next;
      ob_cnt_reg      <= ob_cnt_next;
    end
  end

  assign mem_waddr = wptr_reg;
  assign mem_wdata = in_data;
  assign mem_raddr = rptr_reg;
  assign out_data  = ob_data_reg[0];

  assign depth_sum    = mem_cnt_reg + CWIDTH'(rd_inflight_reg) + CWIDTH'(ob_cnt_reg);
  assign status_depth = rst ? '0 : depth_sum;
  assign status_full  = ~rst & (mem_cnt_reg == DEPTH_C);
  assign status_empty = (status_depth == '0);
  assign idle         = rst | (status_empty & ~in_valid);

endmodule

// File: tb/tb_hqm_aw_tx_sync.sv
`timescale 1ns/1ps
// Bench for hqm_aw_tx_sync: vector table on a DEPTH=4 instance, hand sequences for
// rst_prep/enable/mid-stream reset, and a randomized wrap run on a DEPTH=3 instance.
module tb_hqm_aw_tx_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  // DEPTH=4 instance
  logic        en0, prep0, iv0, ordy0;
  logic [15:0] id0;
  logic        idle0, irdy0, ov0, we0, re0, full0, empty0;
  logic [15:0] od0, wdata0, rdata0;
  logic [1:0]  waddr0, raddr0;
  logic [2:0]  depth0;

  // DEPTH=3 instance
  logic        en1, prep1, iv1, ordy1;
  logic [15:0] id1;
  logic        idle1, irdy1, ov1, we1, re1, full1, empty1;
  logic [15:0] od1, wdata1, rdata1;
  logic [1:0]  waddr1, raddr1;
  logic [2:0]  depth1;

  hqm_aw_tx_sync #(.DEPTH(4), .WIDTH(16)) u0 (
    .hqm_inp_gated_clk(clk), .hqm_inp_gated_rst(rst), .enable(en0), .idle(idle0),
    .rst_prep(prep0), .in_valid(iv0), .in_ready(irdy0), .in_data(id0),
    .out_valid(ov0), .out_ready(ordy0), .out_data(od0),
    .mem_we(we0), .mem_waddr(waddr0), .mem_wdata(wdata0),
    .mem_re(re0), .mem_raddr(raddr0), .mem_rdata(rdata0),
    .status_depth(depth0), .status_full(full0), .status_empty(empty0)
  );

  hqm_aw_tx_sync #(.DEPTH(3), .WIDTH(16)) u1 (
    .hqm_inp_gated_clk(clk), .hqm_inp_gated_rst(rst), .enable(en1), .idle(idle1),
    .rst_prep(prep1), .in_valid(iv1), .in_ready(irdy1), .in_data(id1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1),
    .mem_we(we1), .mem_waddr(waddr1), .mem_wdata(wdata1),
    .mem_re(re1), .mem_raddr(raddr1), .mem_rdata(rdata1),
    .status_depth(depth1), .status_full(full1), .status_empty(empty1)
  );

  // Memory models with registered read
  logic [15:0] mem0 [4];
  logic [15:0] mem1 [3];
  logic        vld1 [3];

  always @(posedge clk) begin
    if (we0) mem0[waddr0] <= wdata0;
    if (re0) rdata0 <= mem0[raddr0];
  end

  always @(posedge clk) begin
    if (we1) mem1[waddr1] <= wdata1;
    if (re1) rdata1 <= mem1[raddr1];
    if (rst) begin
      vld1[0] <= 1'b0;
      vld1[1] <= 1'b0;
      vld1[2] <= 1'b0;
    end else begin
      if (we1) vld1[waddr1] <= 1'b1;
      if (re1) vld1[raddr1] <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic r, input logic en, input logic pr, input logic iv,
                        input logic [15:0] d, input logic ordy);
    @(negedge clk);
    rst = r; en0 = en; prep0 = pr; iv0 = iv; id0 = d; ordy0 = ordy;
    #2;
  endtask

  typedef struct {
    logic        rst, en, prep, iv;
    logic [15:0] id;
    logic        ordy;
    logic        irdy, ov;
    logic [15:0] od;
    logic [2:0]  depth;
    logic        full, we, re, idle;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic en, input logic pr, input logic iv,
                              input logic [15:0] d, input logic ordy, input logic irdy,
                              input logic ov, input logic [15:0] od, input logic [2:0] dep,
                              input logic full, input logic we, input logic re, input logic idl);
    vec_t v;
    v.rst = r; v.en = en; v.prep = pr; v.iv = iv; v.id = d; v.ordy = ordy;
    v.irdy = irdy; v.ov = ov; v.od = od; v.depth = dep;
    v.full = full; v.we = we; v.re = re; v.idle = idl;
    return v;
  endfunction

  vec_t        vt [21];
  logic [15:0] got [$];
  logic [15:0] sb [$];

  initial begin
    rst = 1'b1;
    en0 = 1'b1; prep0 = 1'b0; iv0 = 1'b0; id0 = '0; ordy0 = 1'b0;
    en1 = 1'b1; prep1 = 1'b0; iv1 = 1'b0; id1 = '0; ordy1 = 1'b0;

    //          rst en pr iv id       or  irdy ov od       dep full we re idle
    vt[0]  = mk(1, 1, 0, 1, 16'hBEEF, 0,  0,  0, 16'h0,   0,  0,  0, 0, 1);
    vt[1]  = mk(1, 1, 0, 1, 16'hBEEF, 0,  0,  0, 16'h0,   0,  0,  0, 0, 1);
    vt[2]  = mk(0, 1, 0, 0, 16'h0,    1,  1,  0, 16'h0,   0,  0,  0, 0, 1);
    vt[3]  = mk(0, 1, 0, 1, 16'h1234, 1,  1,  0, 16'h0,   0,  0,  0, 0, 0);
    vt[4]  = mk(0, 1, 0, 0, 16'h0,    1,  1,  1, 16'h1234, 1, 0,  0, 0, 0);
    vt[5]  = mk(0, 1, 0, 0, 16'h0,    1,  1,  0, 16'h0,   0,  0,  0, 0, 1);
    vt[6]  = mk(0, 1, 0, 1, 16'hA0,   0,  1,  0, 16'h0,   0,  0,  0, 0, 0);
    vt[7]  = mk(0, 1, 0, 1, 16'hA1,   0,  1,  1, 16'hA0,  1,  0,  0, 0, 0);
    vt[8]  = mk(0, 1, 0, 1, 16'hA2,   0,  1,  1, 16'hA0,  2,  0,  1, 0, 0);
    vt[9]  = mk(0, 1, 0, 1, 16'hA3,   0,  1,  1, 16'hA0,  3,  0,  1, 0, 0);
    vt[10] = mk(0, 1, 0, 1, 16'hA4,   0,  1,  1, 16'hA0,  4,  0,  1, 0, 0);
    vt[11] = mk(0, 1, 0, 1, 16'hA5,   0,  1,  1, 16'hA0,  5,  0,  1, 0, 0);
    vt[12] = mk(0, 1, 0, 1, 16'hA6,   0,  0,  1, 16'hA0,  6,  1,  0, 0, 0);
    vt[13] = mk(0, 1, 0, 1, 16'hA7,   0,  0,  1, 16'hA0,  6,  1,  0, 0, 0);
    vt[14] = mk(0, 1, 0, 0, 16'h0,    1,  0,  1, 16'hA0,  6,  1,  0, 1, 0);
    vt[15] = mk(0, 1, 0, 0, 16'h0,    1,  1,  1, 16'hA1,  5,  0,  0, 1, 0);
    vt[16] = mk(0, 1, 0, 0, 16'h0,    1,  1,  1, 16'hA2,  4,  0,  0, 1, 0);
    vt[17] = mk(0, 1, 0, 0, 16'h0,    1,  1,  1, 16'hA3,  3,  0,  0, 1, 0);
    vt[18] = mk(0, 1, 0, 0, 16'h0,    1,  1,  1, 16'hA4,  2,  0,  0, 0, 0);
    vt[19] = mk(0, 1, 0, 0, 16'h0,    1,  1,  1, 16'hA5,  1,  0,  0, 0, 0);
    vt[20] = mk(0, 1, 0, 0, 16'h0,    1,  1,  0, 16'h0,   0,  0,  0, 0, 1);

    // Reset, bypass, fill and drain
    for (int i = 0; i < 21; i++) begin
      drive0(vt[i].rst, vt[i].en, vt[i].prep, vt[i].iv, vt[i].id, vt[i].ordy);
      chk($sformatf("v%0d_in_ready", i),  irdy0,  vt[i].irdy);
      chk($sformatf("v%0d_out_valid", i), ov0,    vt[i].ov);
      if (vt[i].ov) chk($sformatf("v%0d_out_data", i), od0, vt[i].od);
      chk($sformatf("v%0d_depth", i),     depth0, vt[i].depth);
      chk($sformatf("v%0d_empty", i),     empty0, (vt[i].depth == 3'd0));
      chk($sformatf("v%0d_full", i),      full0,  vt[i].full);
      chk($sformatf("v%0d_mem_we", i),    we0,    vt[i].we);
      chk($sformatf("v%0d_mem_re", i),    re0,    vt[i].re);
      chk($sformatf("v%0d_idle", i),      idle0,  vt[i].idle);
      $display("vec %0d in_ready=%0b out_valid=%0b out_data=%h depth=%0d", i, irdy0, ov0, od0, depth0);
    end

    // rst_prep freeze with three entries held
    for (int k = 0; k < 3; k++) begin
      drive0(0, 1, 0, 1, 16'h50 + 16'(k), 0);
      chk("prep_fill_ready", irdy0, 1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      drive0(0, 1, 1, 1, 16'hDEAD, 1);
      chk("prep_out_valid", ov0, 1'b0);
      chk("prep_in_ready", irdy0, 1'b0);
      chk("prep_depth", depth0, 3'd3);
      chk("prep_mem_re", re0, 1'b0);
      chk("prep_mem_we", we0, 1'b0);
    end
    got.delete();
    for (int k = 0; k < 8; k++) begin
      drive0(0, 1, 0, 0, 16'h0, 1);
      if (ov0) got.push_back(od0);
    end
    chk("prep_resume_count", got.size(), 3);
    for (int k = 0; k < got.size() && k < 3; k++) chk("prep_resume_order", got[k], 16'h50 + 16'(k));
    $display("rst_prep resume: %0d words", got.size());

    // enable=0 drains, blocks pushes
    for (int k = 0; k < 3; k++) drive0(0, 1, 0, 1, 16'h60 + 16'(k), 0);
    got.delete();
    for (int k = 0; k < 4; k++) begin
      drive0(0, 0, 0, 1, 16'hDEAD, 1);
      chk("en0_in_ready", irdy0, 1'b0);
      if (ov0) got.push_back(od0);
    end
    begin
      int n = 0;
      drive0(0, 0, 0, 0, 16'h0, 1);
      while (!idle0 && n < 10) begin
        if (ov0) got.push_back(od0);
        drive0(0, 0, 0, 0, 16'h0, 1);
        n++;
      end
      chk("en0_idle", idle0, 1'b1);
    end
    chk("en0_drain_count", got.size(), 3);
    for (int k = 0; k < got.size() && k < 3; k++) chk("en0_drain_order", got[k], 16'h60 + 16'(k));
    $display("enable=0 drain: %0d words, idle=%0b", got.size(), idle0);

    // Mid-stream reset with five entries
    for (int k = 0; k < 5; k++) drive0(0, 1, 0, 1, 16'h70 + 16'(k), 0);
    drive0(0, 1, 0, 0, 16'h0, 0);
    chk("mrst_pre_depth", depth0, 3'd5);
    drive0(1, 1, 0, 0, 16'h0, 0);
    chk("mrst_during_ov", ov0, 1'b0);
    chk("mrst_during_depth", depth0, 3'd0);
    drive0(0, 1, 0, 1, 16'h0077, 1);
    chk("mrst_after_depth", depth0, 3'd0);
    chk("mrst_after_ov", ov0, 1'b0);
    chk("mrst_after_in_ready", irdy0, 1'b1);
    chk("mrst_bypass_we", we0, 1'b0);
    drive0(0, 1, 0, 0, 16'h0, 1);
    chk("mrst_bypass_ov", ov0, 1'b1);
    chk("mrst_bypass_data", od0, 16'h0077);
    drive0(0, 1, 0, 0, 16'h0, 1);
    chk("mrst_final_depth", depth0, 3'd0);
    $display("mid-stream reset: bypass word observed");

    // DEPTH=3 wrap run with random handshakes
    begin
      int sent = 0;
      int recvd = 0;
      int cyc = 0;
      int exp_waddr = 0;
      sb.delete();
      while (recvd < 30 && cyc < 2000) begin
        @(negedge clk);
        rst = 1'b0;
        iv1 = (sent < 30) && ($urandom_range(0, 3) != 0);
        id1 = 16'hC000 + 16'(sent);
        ordy1 = ($urandom_range(0, 1) == 1);
        #2;
        if (re1) chk("wrap_read_written_slot", vld1[raddr1], 1'b1);
        if (we1) begin
          chk("wrap_waddr_seq", waddr1, exp_waddr);
          chk("wrap_write_free_slot", vld1[waddr1], 1'b0);
          exp_waddr = (exp_waddr == 2) ? 0 : exp_waddr + 1;
        end
        if (iv1 && irdy1) begin
          sb.push_back(id1);
          sent++;
        end
        if (ov1 && ordy1) begin
          if (sb.size() == 0) chk("wrap_unexpected_pop", 1, 0);
          else chk("wrap_order", od1, sb.pop_front());
          recvd++;
        end
        cyc++;
      end
      chk("wrap_received", recvd, 30);
      @(negedge clk);
      iv1 = 1'b0;
      ordy1 = 1'b0;
      #2;
      chk("wrap_final_empty", empty1, 1'b1);
      chk("wrap_final_idle", idle1, 1'b1);
      $display("wrap run: sent=%0d received=%0d cycles=%0d", sent, recvd, cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
